// File: rtl/timing_pkg.sv
// Shared definitions for the DDR timing-constraint tracker: counter slot
// indices, command codes and the saturating arithmetic helpers.
package timing_pkg;

    // Per-bank counter slots
    localparam int unsigned CNT_PRE = 0;
    localparam int unsigned CNT_ACT = 1;
    localparam int unsigned CNT_RD  = 2;
    localparam int unsigned CNT_WR  = 3;
    localparam int unsigned NUM_CNT = 4;

    // Command codes as seen on issue_cmd; codes 6 and 7 are unused
    localparam int unsigned CMD_PRE    = 0;
    localparam int unsigned CMD_ACT    = 1;
    localparam int unsigned CMD_CASRD  = 2;
    localparam int unsigned CMD_CASRDA = 3;
    localparam int unsigned CMD_CASWR  = 4;
    localparam int unsigned CMD_CASWRA = 5;

    function automatic int unsigned max_t(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned sat_dec(input int unsigned a);
        return (a == 32'd0) ? 32'd0 : a - 32'd1;
    endfunction

endpackage

// File: rtl/tfaw_window.sv
// Four-activate window for one rank: four saturating down-counters written
// round-robin by ACTs. The entry at the write pointer is the oldest ACT.
module tfaw_window
    import timing_pkg::*;
#(
    parameter int unsigned TIME_WIDTH = 16,
    parameter int unsigned T_FAW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  act_push,
    output logic [TIME_WIDTH-1:0] counter,
    output logic                  valid
);

    logic [3:0][TIME_WIDTH-1:0] entry_q;
    logic [3:0][TIME_WIDTH-1:0] entry_d;
    logic [1:0]                 ptr_q;
    logic [1:0]                 ptr_d;
    logic [TIME_WIDTH-1:0]      counter_d;
    logic                       valid_d;

    // Next window state: decay every entry, overwrite the oldest on an ACT
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            entry_d[i] = TIME_WIDTH'(sat_dec(32'(entry_q[i])));
        end
        ptr_d = ptr_q;
        if (act_push) begin
            entry_d[ptr_q] = TIME_WIDTH'(max_t(32'(entry_d[ptr_q]), T_FAW - 32'd1));
            ptr_d          = ptr_q + 2'd1;
        end
        counter_d = entry_d[ptr_d];
        valid_d   = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (entry_d[i] == '0) begin
                valid_d = 1'b0;
            end
        end
    end

    // Window registers; outputs are registered copies of the next-state view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            ptr_q   <= '0;
            counter <= '0;
            valid   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            ptr_q   <= ptr_d;
            counter <= counter_d;
            valid   <= valid_d;
        end
    end

endmodule

// File: rtl/timing_counter_array.sv
// Per-bank / per-rank DDR timing tracker. Each bank keeps one down-counter
// per command class holding the cycles left until that class is legal; each
// rank keeps a four-activate window. Loads never shorten a pending wait.
module timing_counter_array
    import timing_pkg::*;
#(
    parameter int unsigned NUM_BNK_TOT    = 1,
    parameter int unsigned NUM_RNK_TOT    = 1,
    parameter int unsigned CMD_TYPE_WIDTH = 3,
    parameter int unsigned TIME_WIDTH     = 16,
    parameter int unsigned tRP            = 14,
    parameter int unsigned tRCD           = 14,
    parameter int unsigned tRAS           = 32,
    parameter int unsigned tRC            = 46,
    parameter int unsigned tRRD           = 4,
    parameter int unsigned tFAW           = 16,
    parameter int unsigned tCCD           = 4,
    parameter int unsigned tRTP           = 8,
    parameter int unsigned tWR            = 15,
    parameter int unsigned tWTR           = 8,
    parameter int unsigned CWL            = 12,
    parameter int unsigned BL             = 8,
    parameter int unsigned tRD2WR         = 8,
    localparam int unsigned BANK_W        = (NUM_BNK_TOT > 1) ? $clog2(NUM_BNK_TOT) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       issue_valid,
    input  logic [BANK_W-1:0]                          issue_bank,
    input  logic [CMD_TYPE_WIDTH-1:0]                  issue_cmd,
    output logic [NUM_BNK_TOT-1:0][3:0][TIME_WIDTH-1:0] cmd_counter,
    output logic [NUM_RNK_TOT-1:0][TIME_WIDTH-1:0]     tfaw_counter,
    output logic [NUM_RNK_TOT-1:0]                     tfaw_valid
);

    localparam int unsigned BPR     = NUM_BNK_TOT / NUM_RNK_TOT;
    localparam int unsigned WR2RD   = CWL + BL / 2 + tWTR;
    localparam int unsigned WR2PRE  = CWL + BL / 2 + tWR;
    localparam int unsigned RDA2ACT = tRTP + tRP;
    localparam int unsigned WRA2ACT = WR2PRE + tRP;

    localparam longint unsigned T_LIMIT = (64'd1 << TIME_WIDTH) - 64'd1;
    localparam int unsigned T_LARGEST =
        max_t(max_t(max_t(max_t(tRP, tRCD), max_t(tRAS, tRC)),
                    max_t(max_t(tRRD, tFAW), max_t(tCCD, tRTP))),
              max_t(max_t(max_t(tRD2WR, WR2RD), max_t(WR2PRE, RDA2ACT)), WRA2ACT));

    if (TIME_WIDTH < 1 || TIME_WIDTH > 32 || CMD_TYPE_WIDTH < 1 || CMD_TYPE_WIDTH > 32) begin : g_bad_width
        $error("timing_counter_array: TIME_WIDTH and CMD_TYPE_WIDTH must be 1..32");
    end
    if (NUM_BNK_TOT == 0 || NUM_RNK_TOT == 0 || (NUM_BNK_TOT % NUM_RNK_TOT) != 0) begin : g_bad_geom
        $error("timing_counter_array: NUM_BNK_TOT must be a nonzero multiple of NUM_RNK_TOT");
    end
    if (tRP == 0 || tRCD == 0 || tRAS == 0 || tRC == 0 || tRRD == 0 || tFAW == 0 ||
        tCCD == 0 || tRTP == 0 || tWR == 0 || tWTR == 0 || CWL == 0 || BL == 0 ||
        tRD2WR == 0) begin : g_bad_zero
        $error("timing_counter_array: every timing parameter must be at least 1");
    end
    if (longint'(T_LARGEST) > T_LIMIT) begin : g_bad_range
        $error("timing_counter_array: a timing constant does not fit in TIME_WIDTH bits");
    end

    logic [NUM_BNK_TOT-1:0][3:0][TIME_WIDTH-1:0] cnt_q;
    logic [NUM_BNK_TOT-1:0][3:0][TIME_WIDTH-1:0] cnt_d;
    int unsigned                                 req [NUM_BNK_TOT][NUM_CNT];
    int unsigned                                 cmd_i;
    int unsigned                                 bank_i;
    int unsigned                                 rank_i;
    logic                                        bank_ok;
    logic                                        is_act;
    logic [NUM_RNK_TOT-1:0]                      act_push;

    assign cmd_i   = 32'(issue_cmd);
    assign bank_i  = 32'(issue_bank);
    assign rank_i  = bank_i / BPR;
    assign bank_ok = issue_valid && (bank_i < NUM_BNK_TOT);
    assign is_act  = bank_ok && (cmd_i == CMD_ACT);

    // Constraint requests raised by this cycle's issue; 0 means no load.
    // Rules that hit the same counter within one issue combine by max.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BNK_TOT; b++) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                req[b][k] = 32'd0;
            end
        end
        if (bank_ok) begin
            for (int unsigned b = 0; b < NUM_BNK_TOT; b++) begin
                if ((b / BPR) == rank_i) begin
                    case (cmd_i)
                        CMD_ACT: begin
                            if (b != bank_i) begin
                                req[b][CNT_ACT] = max_t(req[b][CNT_ACT], tRRD);
                            end
                        end
                        CMD_CASRD, CMD_CASRDA: begin
                            req[b][CNT_RD] = max_t(req[b][CNT_RD], tCCD);
                            req[b][CNT_WR] = max_t(req[b][CNT_WR], tRD2WR);
                        end
                        CMD_CASWR, CMD_CASWRA: begin
                            req[b][CNT_WR] = max_t(req[b][CNT_WR], tCCD);
                            req[b][CNT_RD] = max_t(req[b][CNT_RD], WR2RD);
                        end
                        default: ;
                    endcase
                end
                if (b == bank_i) begin
                    case (cmd_i)
                        CMD_PRE: begin
                            req[b][CNT_ACT] = max_t(req[b][CNT_ACT], tRP);
                        end
                        CMD_ACT: begin
                            req[b][CNT_PRE] = max_t(req[b][CNT_PRE], tRAS);
                            req[b][CNT_RD]  = max_t(req[b][CNT_RD], tRCD);
                            req[b][CNT_WR]  = max_t(req[b][CNT_WR], tRCD);
                            req[b][CNT_ACT] = max_t(req[b][CNT_ACT], tRC);
                        end
                        CMD_CASRD: begin
                            req[b][CNT_PRE] = max_t(req[b][CNT_PRE], tRTP);
                        end
                        CMD_CASRDA: begin
                            req[b][CNT_PRE] = max_t(req[b][CNT_PRE], tRTP);
                            req[b][CNT_ACT] = max_t(req[b][CNT_ACT], RDA2ACT);
                        end
                        CMD_CASWR: begin
                            req[b][CNT_PRE] = max_t(req[b][CNT_PRE], WR2PRE);
                        end
                        CMD_CASWRA: begin
                            req[b][CNT_PRE] = max_t(req[b][CNT_PRE], WR2PRE);
                            req[b][CNT_ACT] = max_t(req[b][CNT_ACT], WRA2ACT);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Next counter values: decay, then raise to T-1 wherever a constraint applies
    always_comb begin
        for (int unsigned b = 0; b < NUM_BNK_TOT; b++) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) begin
                cnt_d[b][k] = TIME_WIDTH'(max_t(sat_dec(32'(cnt_q[b][k])),
                                                (req[b][k] == 32'd0) ? 32'd0 : req[b][k] - 32'd1));
            end
        end
    end

    // Per-rank ACT strobes for the four-activate windows
    always_comb begin
        for (int unsigned r = 0; r < NUM_RNK_TOT; r++) begin
            act_push[r] = is_act && (r == rank_i);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cmd_counter = cnt_q;

    for (genvar r = 0; r < NUM_RNK_TOT; r++) begin : g_rank
        tfaw_window #(
            .TIME_WIDTH (TIME_WIDTH),
            .T_FAW      (tFAW)
        ) u_tfaw_window (
            .clk      (clk),
            .rst_n    (rst_n),
            .act_push (act_push[r]),
            .counter  (tfaw_counter[r]),
            .valid    (tfaw_valid[r])
        );
    end

endmodule

// File: tb/tb_timing_counter_array.sv
// Scoreboard bench for timing_counter_array (6 banks, 2 ranks). The reference
// model tracks, per bank and class, the absolute cycle at which the class
// becomes legal, and per rank the issue times of the last four ACTs.
module tb_timing_counter_array;
    import timing_pkg::*;

    localparam int NB  = 6;
    localparam int NR  = 2;
    localparam int TW  = 16;
    localparam int BW  = 3;
    localparam int BPR = NB / NR;

    localparam longint T_RP = 14, T_RCD = 14, T_RAS = 32, T_RC = 46, T_RRD = 4;
    localparam longint T_FAW = 16, T_CCD = 4, T_RTP = 8, T_RD2WR = 8;
    localparam longint WR2RD   = 12 + 8 / 2 + 8;
    localparam longint WR2PRE  = 12 + 8 / 2 + 15;
    localparam longint RDA2ACT = 8 + 14;
    localparam longint WRA2ACT = WR2PRE + 14;

    typedef struct packed {
        logic [NB-1:0][3:0][TW-1:0] cnt;
        logic [NR-1:0][TW-1:0]      tfc;
        logic [NR-1:0]              tfv;
    } snap_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       issue_valid = 1'b0;
    logic [BW-1:0]              issue_bank = '0;
    logic [2:0]                 issue_cmd = '0;
    logic [NB-1:0][3:0][TW-1:0] cmd_counter;
    logic [NR-1:0][TW-1:0]      tfaw_counter;
    logic [NR-1:0]              tfaw_valid;

    timing_counter_array #(
        .NUM_BNK_TOT (NB),
        .NUM_RNK_TOT (NR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_bank   (issue_bank),
        .issue_cmd    (issue_cmd),
        .cmd_counter  (cmd_counter),
        .tfaw_counter (tfaw_counter),
        .tfaw_valid   (tfaw_valid)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    snap_t sb [$];

    longint ready [NB][4];
    longint hist  [NR][4];
    int     hist_n [NR];

    function automatic void ld(input int bk, input int k, input longint t);
        if (t > ready[bk][k]) ready[bk][k] = t;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 4; k++) ready[b][k] = 0;
        for (int r = 0; r < NR; r++) hist_n[r] = 0;
    endfunction

    function automatic void model_issue(input bit v, input int b, input int c, input longint e);
        int r;
        if (!v || b >= NB || c > 5) return;
        r = b / BPR;
        case (c)
            CMD_PRE: ld(b, CNT_ACT, e + T_RP);
            CMD_ACT: begin
                ld(b, CNT_PRE, e + T_RAS);
                ld(b, CNT_RD,  e + T_RCD);
                ld(b, CNT_WR,  e + T_RCD);
                ld(b, CNT_ACT, e + T_RC);
                for (int o = r * BPR; o < (r + 1) * BPR; o++)
                    if (o != b) ld(o, CNT_ACT, e + T_RRD);
                for (int i = 0; i < 3; i++) hist[r][i] = hist[r][i + 1];
                hist[r][3] = e;
                hist_n[r]++;
            end
            CMD_CASRD, CMD_CASRDA: begin
                for (int o = r * BPR; o < (r + 1) * BPR; o++) begin
                    ld(o, CNT_RD, e + T_CCD);
                    ld(o, CNT_WR, e + T_RD2WR);
                end
                ld(b, CNT_PRE, e + T_RTP);
                if (c == CMD_CASRDA) ld(b, CNT_ACT, e + RDA2ACT);
            end
            default: begin
                for (int o = r * BPR; o < (r + 1) * BPR; o++) begin
                    ld(o, CNT_WR, e + T_CCD);
                    ld(o, CNT_RD, e + WR2RD);
                end
                ld(b, CNT_PRE, e + WR2PRE);
                if (c == CMD_CASWRA) ld(b, CNT_ACT, e + WRA2ACT);
            end
        endcase
    endfunction

    // Expected outputs during cycle c (after the edge with index c-1)
    function automatic snap_t expect_at(input longint c);
        snap_t s;
        s = '0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 4; k++)
                if (ready[b][k] > c) s.cnt[b][k] = TW'(ready[b][k] - c);
        for (int r = 0; r < NR; r++)
            if (hist_n[r] >= 4 && hist[r][0] + T_FAW > c) begin
                s.tfc[r] = TW'(hist[r][0] + T_FAW - c);
                s.tfv[r] = 1'b1;
            end
        return s;
    endfunction

    task automatic compare_all(input snap_t exp, input string tag);
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cmd_counter[b][k] !== exp.cnt[b][k]) begin
                    errors++;
                    $display("FAIL %s cnt[%0d][%0d] cycle %0d: got %0d expected %0d",
                             tag, b, k, cyc, cmd_counter[b][k], exp.cnt[b][k]);
                end
            end
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (tfaw_counter[r] !== exp.tfc[r]) begin
                errors++;
                $display("FAIL %s tfaw_counter[%0d] cycle %0d: got %0d expected %0d",
                         tag, r, cyc, tfaw_counter[r], exp.tfc[r]);
            end
            checks++;
            if (tfaw_valid[r] !== exp.tfv[r]) begin
                errors++;
                $display("FAIL %s tfaw_valid[%0d] cycle %0d: got %0b expected %0b",
                         tag, r, cyc, tfaw_valid[r], exp.tfv[r]);
            end
        end
    endtask

    // Monitor: one expected snapshot per driven edge, compared just after it
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) compare_all(sb.pop_front(), "sb");
    end

    task automatic step(input bit v, input int b, input int c);
        @(negedge clk);
        issue_valid = v;
        issue_bank  = BW'(b);
        issue_cmd   = 3'(c);
        if (rst_n) model_issue(v, b, c, cyc);
        sb.push_back(expect_at(cyc + 1));
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, CMD_ACT);
    endtask

    // Async assert mid-cycle, two held edges with ignored ACTs, release mid-cycle
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all('0, "async_rst");
        step(1'b1, 0, CMD_ACT);
        step(1'b1, 3, CMD_ACT);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        reset_pulse();

        // Single ACT then long idle: everything drains to 0 and stays there
        step(1'b1, 0, CMD_ACT);
        idle(60);

        // Max rule: PRE after a long ACT wait, then WR/RD turnaround on bank 1
        step(1'b1, 0, CMD_ACT);
        idle(34);
        step(1'b1, 0, CMD_PRE);
        idle(4);
        step(1'b1, 1, CMD_CASWR);
        idle(3);
        step(1'b1, 1, CMD_CASRD);
        idle(50);

        // Four-activate window on rank 0, fifth ACT after it expires
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i % BPR, CMD_ACT);
            if (i < 3) idle(3);
        end
        idle(7);
        step(1'b1, 1, CMD_ACT);
        idle(30);

        // Same on rank 1, plus auto-precharge variants
        for (int i = 0; i < 4; i++) begin
            step(1'b1, BPR + i % BPR, CMD_ACT);
            idle(2);
        end
        step(1'b1, 4, CMD_CASRDA);
        step(1'b1, 5, CMD_CASWRA);
        idle(60);

        // Ignored issues: out-of-range banks, unused codes, valid low
        step(1'b1, 0, CMD_ACT);
        step(1'b1, 7, CMD_ACT);
        step(1'b1, 6, CMD_CASWR);
        step(1'b1, 2, 6);
        step(1'b1, 4, 7);
        step(1'b0, 1, CMD_PRE);
        idle(5);

        // Reset mid-run, then the window pointer must restart from entry 0
        step(1'b1, 0, CMD_ACT);
        idle(9);
        reset_pulse();
        for (int i = 0; i < 4; i++) step(1'b1, i % BPR, CMD_ACT);
        idle(20);

        // Randomized traffic including unused codes and out-of-range banks
        repeat (700) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else step(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        idle(60);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
